// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer:
//   - opcode encodings (5-bit decode table, register and immediate forms)
//   - op_en bit indices, one per execution unit (17 units)
//   - FSM state type and state constants
//   - helper to build a one-hot unit enable from a bit index
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEC_W   = 5;   // width of the decode table
    localparam int N_UNITS = 17;  // number of op_en bits
    localparam int CNT_W   = 4;   // execute-cycle down-counter width

    // op_en bit indices
    localparam int U_ADD  = 0;
    localparam int U_SUB  = 1;
    localparam int U_MUL  = 2;
    localparam int U_DIV  = 3;
    localparam int U_MOD  = 4;
    localparam int U_MAX  = 5;
    localparam int U_MIN  = 6;
    localparam int U_NOT  = 7;
    localparam int U_NAND = 8;
    localparam int U_XNOR = 9;
    localparam int U_SHL  = 10;
    localparam int U_SHRL = 11;
    localparam int U_ROL  = 12;
    localparam int U_ROR  = 13;
    localparam int U_SLT  = 14;
    localparam int U_BEQ  = 15;
    localparam int U_BLT  = 16;

    // Opcode encodings; *_I are the immediate forms (10010..10111)
    localparam logic [DEC_W-1:0] OPC_NOP    = 5'b00000;
    localparam logic [DEC_W-1:0] OPC_ADD    = 5'b00001;
    localparam logic [DEC_W-1:0] OPC_SUB    = 5'b00010;
    localparam logic [DEC_W-1:0] OPC_MUL    = 5'b00011;
    localparam logic [DEC_W-1:0] OPC_DIV    = 5'b00100;
    localparam logic [DEC_W-1:0] OPC_MOD    = 5'b00101;
    localparam logic [DEC_W-1:0] OPC_MAX    = 5'b00110;
    localparam logic [DEC_W-1:0] OPC_MIN    = 5'b00111;
    localparam logic [DEC_W-1:0] OPC_NOT    = 5'b01000;
    localparam logic [DEC_W-1:0] OPC_NAND   = 5'b01001;
    localparam logic [DEC_W-1:0] OPC_XNOR   = 5'b01010;
    localparam logic [DEC_W-1:0] OPC_SHL    = 5'b01011;
    localparam logic [DEC_W-1:0] OPC_SHRL   = 5'b01100;
    localparam logic [DEC_W-1:0] OPC_ROL    = 5'b01101;
    localparam logic [DEC_W-1:0] OPC_ROR    = 5'b01110;
    localparam logic [DEC_W-1:0] OPC_SLT    = 5'b01111;
    localparam logic [DEC_W-1:0] OPC_ADD_I  = 5'b10010;
    localparam logic [DEC_W-1:0] OPC_SUB_I  = 5'b10011;
    localparam logic [DEC_W-1:0] OPC_MUL_I  = 5'b10100;
    localparam logic [DEC_W-1:0] OPC_DIV_I  = 5'b10101;
    localparam logic [DEC_W-1:0] OPC_NAND_I = 5'b10110;
    localparam logic [DEC_W-1:0] OPC_XNOR_I = 5'b10111;
    localparam logic [DEC_W-1:0] OPC_BEQ    = 5'b11110;
    localparam logic [DEC_W-1:0] OPC_BLT    = 5'b11111;

    // FSM state: plain vector type with named constants
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EXEC = 1'b1;

    function automatic logic [N_UNITS-1:0] unit_bit(input int idx);
        return N_UNITS'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode decoder.
// Ports:
//   i_opcode  [4:0]  opcode to decode
//   o_op_en   [16:0] one-hot unit enable (all zero for NOP / unmapped)
//   o_is_imm         opcode is an immediate form (10010..10111)
//   o_multi          opcode needs the multi-cycle MUL/DIV/MOD latency
//   o_legal          opcode is mapped (00000 counts as a legal NOP)
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [DEC_W-1:0]   i_opcode,
    output logic [N_UNITS-1:0] o_op_en,
    output logic               o_is_imm,
    output logic               o_multi,
    output logic               o_legal
);

    always_comb begin
        o_op_en = '0;
        o_multi = 1'b0;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_NOP:               begin end
            OPC_ADD,  OPC_ADD_I:   o_op_en = unit_bit(U_ADD);
            OPC_SUB,  OPC_SUB_I:   o_op_en = unit_bit(U_SUB);
            OPC_MUL,  OPC_MUL_I:   begin o_op_en = unit_bit(U_MUL); o_multi = 1'b1; end
            OPC_DIV,  OPC_DIV_I:   begin o_op_en = unit_bit(U_DIV); o_multi = 1'b1; end
            OPC_MOD:               begin o_op_en = unit_bit(U_MOD); o_multi = 1'b1; end
            OPC_MAX:               o_op_en = unit_bit(U_MAX);
            OPC_MIN:               o_op_en = unit_bit(U_MIN);
            OPC_NOT:               o_op_en = unit_bit(U_NOT);
            OPC_NAND, OPC_NAND_I:  o_op_en = unit_bit(U_NAND);
            OPC_XNOR, OPC_XNOR_I:  o_op_en = unit_bit(U_XNOR);
            OPC_SHL:               o_op_en = unit_bit(U_SHL);
            OPC_SHRL:              o_op_en = unit_bit(U_SHRL);
            OPC_ROL:               o_op_en = unit_bit(U_ROL);
            OPC_ROR:               o_op_en = unit_bit(U_ROR);
            OPC_SLT:               o_op_en = unit_bit(U_SLT);
            OPC_BEQ:               o_op_en = unit_bit(U_BEQ);
            OPC_BLT:               o_op_en = unit_bit(U_BLT);
            default:               o_legal = 1'b0;
        endcase
        // The immediate forms occupy one contiguous code range.
        o_is_imm = (i_opcode >= OPC_ADD_I) && (i_opcode <= OPC_XNOR_I);
    end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Accepts one opcode at a time, decodes it and holds registered unit enables
// for the execute duration (1 cycle, or MULDIV_LAT cycles for MUL/DIV/MOD).
// Back-to-back single-cycle ops stream at one per cycle.
// Parameters:
//   OPCODE_W   opcode width (only 5 is supported by the decode table)
//   MULDIV_LAT execute cycles for MUL/DIV/MOD, 1..15
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    opcode offered;   in_opcode  offered opcode
//   in_ready    opcode can be accepted this cycle
//   abort       cancel the operation in flight (ignored when idle)
//   op_en       one-hot unit enables (registered, zero when idle)
//   is_imm      current op is an immediate form (registered)
//   busy        executing;        done       pulse on final execute cycle
//   illegal_op  pulse with done for an unmapped opcode
// Build option: define ALU_SEQ_ILLEGAL_TRAP_EN to add the illegal_op port;
// without it unmapped opcodes are silent NOPs.
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int OPCODE_W   = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [OPCODE_W-1:0] in_opcode,
    output logic                in_ready,
    input  logic                abort,
    output logic [N_UNITS-1:0]  op_en,
    output logic                is_imm,
    output logic                busy,
    output logic                done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;     // execute cycles remaining, including current
    logic [N_UNITS-1:0] r_op_en;
    logic               r_is_imm;

    logic [DEC_W-1:0]   w_opcode;
    logic [N_UNITS-1:0] w_dec_en;
    logic               w_dec_imm;
    logic               w_dec_multi;
    logic               w_dec_legal;
    logic               w_exec;
    logic               w_last;
    logic               w_abort_exec;
    logic               w_accept;

    assign w_opcode = DEC_W'(in_opcode);

    alu_op_decode u_decode (
        .i_opcode (w_opcode),
        .o_op_en  (w_dec_en),
        .o_is_imm (w_dec_imm),
        .o_multi  (w_dec_multi),
        .o_legal  (w_dec_legal)
    );

    assign w_exec       = (r_state == ST_EXEC);
    assign w_last       = w_exec && (r_cnt == CNT_W'(1));
    assign w_abort_exec = w_exec && abort;

    // An abort on the final cycle both kills done and closes the accept
    // window, so in_ready can be expressed through done.
    assign done     = w_last && !abort;
    assign in_ready = !w_exec || done;
    assign w_accept = in_valid && in_ready;
    assign busy     = w_exec;
    assign op_en    = r_op_en;
    assign is_imm   = r_is_imm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op_en  <= '0;
            r_is_imm <= 1'b0;
        end else if (w_abort_exec) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op_en  <= '0;
            r_is_imm <= 1'b0;
        end else if (w_accept) begin
            r_state  <= ST_EXEC;
            r_cnt    <= w_dec_multi ? MULDIV_CNT : CNT_W'(1);
            r_op_en  <= w_dec_en;
            r_is_imm <= w_dec_imm;
        end else if (w_last) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op_en  <= '0;
            r_is_imm <= 1'b0;
        end else if (w_exec) begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Latched at acceptance; 00000 decodes as legal so it never traps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_abort_exec) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= !w_dec_legal;
        end else if (w_last) begin
            r_illegal <= 1'b0;
        end
    end

    assign illegal_op = done && r_illegal;
`else
    logic w_unused_legal;
    assign w_unused_legal = w_dec_legal;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model built from the opcode table.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to exercise the illegal_op port as well.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_opcode = '0;
    logic        abort = 1'b0;
    logic        in_ready;
    logic [16:0] op_en;
    logic        is_imm;
    logic        busy;
    logic        done;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    always #5 clk = ~clk;

    alu_sequencer #(.OPCODE_W(5), .MULDIV_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_ready   (in_ready),
        .abort      (abort),
        .op_en      (op_en),
        .is_imm     (is_imm),
        .busy       (busy),
        .done       (done)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
        end
    endtask

    // Opcode table: unit index (-1 = none), plus flags
    int unit_of[32];
    bit imm_of[32];
    bit multi_of[32];
    bit legal_of[32];

    task automatic map_op(input int opc, input int unit);
        unit_of[opc]  = unit;
        legal_of[opc] = 1'b1;
        multi_of[opc] = (unit == 2) || (unit == 3) || (unit == 4);
    endtask

    task automatic build_table();
        for (int i = 0; i < 32; i++) begin
            unit_of[i] = -1; legal_of[i] = 1'b0; multi_of[i] = 1'b0;
            imm_of[i]  = (i >= 18) && (i <= 23);
        end
        legal_of[0] = 1'b1;
        map_op(1, 0);  map_op(18, 0);   // ADD
        map_op(2, 1);  map_op(19, 1);   // SUB
        map_op(3, 2);  map_op(20, 2);   // MUL
        map_op(4, 3);  map_op(21, 3);   // DIV
        map_op(5, 4);                   // remainder
        map_op(6, 5);  map_op(7, 6);    // MAX MIN
        map_op(8, 7);                   // NOT
        map_op(9, 8);  map_op(22, 8);   // NAND
        map_op(10, 9); map_op(23, 9);   // XNOR
        map_op(11, 10); map_op(12, 11); map_op(13, 12); map_op(14, 13);
        map_op(15, 14); map_op(30, 15); map_op(31, 16);
    endtask

    // Reference model: the operation currently executing, if any
    bit m_busy = 1'b0;
    int m_left = 0;
    int m_unit = -1;
    bit m_imm  = 1'b0;
    bit m_ill  = 1'b0;

    task automatic step(input bit v, input logic [4:0] opc, input bit ab);
        logic [16:0] exp_en;
        bit exp_done, exp_ready, exp_last;
        @(negedge clk);
        in_valid = v; in_opcode = opc; abort = ab;
        #1;
        exp_en    = (m_busy && m_unit >= 0) ? (17'd1 << m_unit) : 17'd0;
        exp_last  = m_busy && (m_left == 1);
        exp_done  = exp_last && !ab;
        exp_ready = !m_busy || exp_done;
        check_val("op_en",    op_en,    exp_en);
        check_val("is_imm",   is_imm,   m_busy && m_imm);
        check_val("busy",     busy,     m_busy);
        check_val("done",     done,     exp_done);
        check_val("in_ready", in_ready, exp_ready);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check_val("illegal_op", illegal_op, exp_done && m_ill);
`endif
        if (m_busy && ab) begin
            m_busy = 1'b0;
            $display("[TB] cycle %0d abort", cycle);
        end else if (v && exp_ready) begin
            m_busy = 1'b1;
            m_left = multi_of[opc] ? LAT : 1;
            m_unit = unit_of[opc];
            m_imm  = imm_of[opc];
            m_ill  = !legal_of[opc];
            $display("[TB] cycle %0d accept opcode %b", cycle, opc);
        end else if (exp_last) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
        end
        cycle++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_op_en"},  op_en,  17'd0);
        check_val({tag, "_is_imm"}, is_imm, 1'b0);
        check_val({tag, "_busy"},   busy,   1'b0);
        check_val({tag, "_done"},   done,   1'b0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check_val({tag, "_illegal"}, illegal_op, 1'b0);
`endif
    endtask

    initial begin
        build_table();
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // single ADD, then idle
        step(1, 5'b00001, 0); step(0, 0, 0); step(0, 0, 0);
        // MUL immediate, with a valid held during execute (must be ignored)
        step(1, 5'b10100, 0); step(1, 5'b00010, 0); step(1, 5'b00010, 0);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        // SUB, NOT, BLT streamed back to back
        step(1, 5'b00010, 0); step(1, 5'b01000, 0); step(1, 5'b11111, 0);
        step(0, 0, 0); step(0, 0, 0);
        // DIV aborted on its 2nd execute cycle
        step(1, 5'b00100, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
        // abort on last cycle of a single-cycle op, abort while idle
        step(1, 5'b00110, 0); step(1, 5'b00111, 1); step(1, 5'b01001, 1);
        step(0, 0, 0);
        // unmapped opcode, then explicit NOP 00000
        step(1, 5'b11000, 0); step(1, 5'b00000, 0); step(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 15) == 0);
        end
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

        // reset in the middle of a MOD
        step(1, 5'b00101, 0); step(0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        check_val("rst_mid_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        m_busy = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
